// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-wide memory port between an I-cache refill
// requester and a D-cache refill/write-back requester. A granted requester
// owns the port for a full line of LINE_WORDS beats, one beat per mem_ack.
//
// Ports:
//   clk, n_rst          clock, asynchronous active-low reset
//   i_req, i_addr       I-cache line refill request and miss address
//   d_req, d_we,        D-cache line request, 1 = write-back / 0 = refill,
//   d_addr, d_wdata     line address, write-back word (selected by word_idx)
//   mem_req, mem_we,    memory request, write enable,
//   mem_addr, mem_wdata word address, write data
//   mem_ack, mem_rdata  beat completion and read data from memory
//   rdata               mem_rdata passed through to both caches
//   i_valid, d_valid    rdata is an I / D fill word this cycle
//   word_idx            word index of the current beat
//   i_done, d_done      one-cycle line-complete pulses
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          i_req,
    input  logic [ADDR_W-1:0]             i_addr,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [ADDR_W-1:0]             d_addr,
    input  logic [DATA_W-1:0]             d_wdata,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_ack,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [DATA_W-1:0]             rdata,
    output logic                          i_valid,
    output logic                          d_valid,
    output logic [$clog2(LINE_WORDS)-1:0] word_idx,
    output logic                          i_done,
    output logic                          d_done
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic                       r_grant_d;   // 1 = D owns the port, 0 = I
    logic                       r_last_d;    // 1 = last grant went to D
    logic                       r_we;
    logic [ADDR_W-IDX_W-1:0]    r_base;      // line base, word bits dropped
    logic [IDX_W-1:0]           r_idx;
    logic                       w_pick_d;
    logic                       w_any_req;
    logic                       w_last_beat;

    // Round-robin: D wins when alone, or on contention when I went last.
    assign w_any_req   = i_req | d_req;
    assign w_pick_d    = d_req & (~i_req | ~r_last_d);
    assign w_last_beat = (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= IDLE;
            r_grant_d <= 1'b0;
            r_last_d  <= 1'b0;
            r_we      <= 1'b0;
            r_base    <= '0;
            r_idx     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant_d <= w_pick_d;
                        r_last_d  <= w_pick_d;
                        r_we      <= w_pick_d & d_we;
                        r_base    <= w_pick_d ? d_addr[ADDR_W-1:IDX_W]
                                              : i_addr[ADDR_W-1:IDX_W];
                        r_idx     <= '0;
                    end
                end
                XFER: begin
                    if (mem_ack) begin
                        r_idx <= w_last_beat ? '0 : r_idx + IDX_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_valid   = 1'b0;
        d_valid   = 1'b0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_next = XFER;
                end
            end
            XFER: begin
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_addr  = {r_base, r_idx};
                mem_wdata = d_wdata;
                i_valid   = mem_ack & ~r_grant_d;
                d_valid   = mem_ack & r_grant_d & ~r_we;
                if (mem_ack && w_last_beat) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                i_done = ~r_grant_d;
                d_done = r_grant_d;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign rdata    = mem_rdata;
    assign word_idx = r_idx;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (defaults: 16-bit address/data, 4-word lines).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] rdata;
    logic        i_valid;
    logic        d_valid;
    logic [1:0]  word_idx;
    logic        i_done;
    logic        d_done;

    int vectors    = 0;
    int miscompares = 0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LINE_WORDS(4)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .rdata     (rdata),
        .i_valid   (i_valid),
        .d_valid   (d_valid),
        .word_idx  (word_idx),
        .i_done    (i_done),
        .d_done    (d_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Quiet-port check for cycles where no transfer or done pulse may show.
    task automatic chk_quiet(input string tag);
        chk({tag, ".mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, ".mem_we"},  32'(mem_we),  32'd0);
        chk({tag, ".i_valid"}, 32'(i_valid), 32'd0);
        chk({tag, ".d_valid"}, 32'(d_valid), 32'd0);
        chk({tag, ".i_done"},  32'(i_done),  32'd0);
        chk({tag, ".d_done"},  32'(d_done),  32'd0);
    endtask

    // Entered in the first XFER cycle; returns in the DONE cycle.
    task automatic do_line(input string tag, input logic [15:0] base,
                           input bit is_i, input bit is_wb,
                           input int waits, input int drop_after);
        int          nvalid;
        logic [15:0] wd;
        logic [15:0] rd;
        nvalid = 0;
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < waits; w++) begin
                mem_ack = 1'b0;
                wd = 16'($urandom);
                d_wdata = wd;
                #1;
                chk({tag, ".wait.addr"},  32'(mem_addr), 32'(base + 16'(b)));
                chk({tag, ".wait.idx"},   32'(word_idx), 32'(b));
                chk({tag, ".wait.req"},   32'(mem_req),  32'd1);
                chk({tag, ".wait.valid"}, 32'(i_valid | d_valid), 32'd0);
                nvalid += int'(i_valid) + int'(d_valid);
                tick();
            end
            mem_ack = 1'b1;
            rd = 16'($urandom);
            wd = 16'($urandom);
            mem_rdata = rd;
            d_wdata = wd;
            #1;
            chk({tag, ".req"},     32'(mem_req),   32'd1);
            chk({tag, ".we"},      32'(mem_we),    32'(is_wb));
            chk({tag, ".addr"},    32'(mem_addr),  32'(base + 16'(b)));
            chk({tag, ".idx"},     32'(word_idx),  32'(b));
            chk({tag, ".wdata"},   32'(mem_wdata), 32'(wd));
            chk({tag, ".rdata"},   32'(rdata),     32'(rd));
            chk({tag, ".i_valid"}, 32'(i_valid),   32'(is_i));
            chk({tag, ".d_valid"}, 32'(d_valid),   32'(!is_i && !is_wb));
            chk({tag, ".done"},    32'(i_done | d_done), 32'd0);
            nvalid += int'(i_valid) + int'(d_valid);
            if (b == drop_after) begin
                d_req  = 1'b0;
                d_we   = ~d_we;
                d_addr = 16'hFFFF;
                i_addr = 16'hFFFF;
            end
            tick();
        end
        // DONE cycle: a stray mem_ack here must be ignored.
        mem_ack = 1'b1;
        #1;
        chk({tag, ".done.req"},   32'(mem_req), 32'd0);
        chk({tag, ".done.valid"}, 32'(i_valid | d_valid), 32'd0);
        chk({tag, ".done.idx"},   32'(word_idx), 32'd0);
        chk({tag, ".i_done"},     32'(i_done), 32'(is_i));
        chk({tag, ".d_done"},     32'(d_done), 32'(!is_i));
        chk({tag, ".nvalid"},     32'(nvalid), (is_i || !is_wb) ? 32'd4 : 32'd0);
    endtask

    initial begin
        n_rst = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        i_addr = 16'h1111; d_addr = 16'h2222; d_wdata = 16'h3333;
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        #3;
        // Reset holds everything quiet even with requests and acks present.
        chk_quiet("rst0");
        chk("rst0.addr",  32'(mem_addr),  32'd0);
        chk("rst0.wdata", 32'(mem_wdata), 32'd0);
        chk("rst0.idx",   32'(word_idx),  32'd0);
        chk("rst0.rdata", 32'(rdata),     32'hBEEF);
        tick(); tick();
        chk_quiet("rst1");
        i_req = 1'b0; d_req = 1'b0;
        n_rst = 1'b1;
        tick();
        chk_quiet("idle0");

        // D refill of line 0x1234, ack every cycle.
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h1237;
        #1;
        chk("t1.grant_cycle.req", 32'(mem_req), 32'd0);
        tick();
        do_line("t1", 16'h1234, 1'b0, 1'b0, 0, -1);
        d_req = 1'b0;
        tick();
        chk_quiet("t1.after");

        // Contention right after reset: D first; D re-requests while I waits,
        // so the next simultaneous pair goes to I, then D.
        n_rst = 1'b0;
        #1;
        n_rst = 1'b1;
        tick();
        i_req = 1'b1; d_req = 1'b1; i_addr = 16'h0101; d_addr = 16'h0202;
        tick();
        do_line("t2a", 16'h0200, 1'b0, 1'b0, 0, -1);
        d_addr = 16'h0303;
        tick();
        chk_quiet("t2a.after");
        tick();
        do_line("t2b", 16'h0100, 1'b1, 1'b0, 0, -1);
        i_req = 1'b0;
        tick();
        chk_quiet("t2b.after");
        tick();
        do_line("t2c", 16'h0300, 1'b0, 1'b0, 0, -1);
        d_req = 1'b0;
        tick();
        chk_quiet("t2c.after");

        // I refill with three wait cycles per beat.
        i_req = 1'b1; i_addr = 16'h4442;
        tick();
        do_line("t3", 16'h4440, 1'b1, 1'b0, 3, -1);
        i_req = 1'b0;
        tick();
        chk_quiet("t3.after");

        // D write-back.
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h5555;
        tick();
        do_line("t4", 16'h5554, 1'b0, 1'b1, 0, -1);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        chk_quiet("t4.after");

        // Reset after two beats of a D refill.
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h6660;
        tick();
        mem_ack = 1'b1;
        tick();
        tick();
        chk("t5.pre.idx",  32'(word_idx), 32'd2);
        chk("t5.pre.addr", 32'(mem_addr), 32'h6662);
        mem_rdata = 16'hA5A5;
        n_rst = 1'b0;
        #1;
        chk_quiet("t5.rst");
        chk("t5.rst.addr",  32'(mem_addr), 32'd0);
        chk("t5.rst.idx",   32'(word_idx), 32'd0);
        chk("t5.rst.rdata", 32'(rdata),    32'hA5A5);
        d_req = 1'b0;
        tick();
        chk_quiet("t5.rst2");
        n_rst = 1'b1;
        tick();
        chk_quiet("t5.post1");
        tick();
        chk_quiet("t5.post2");
        i_req = 1'b1; i_addr = 16'h0ABE;
        tick();
        do_line("t5", 16'h0ABC, 1'b1, 1'b0, 0, -1);
        i_req = 1'b0;
        tick();
        chk_quiet("t5.after");

        // D request dropped after beat 1, with d_we/d_addr/i_addr disturbed.
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h7777;
        tick();
        do_line("t6", 16'h7774, 1'b0, 1'b0, 0, 1);
        tick();
        chk_quiet("t6.after1");
        tick();
        chk_quiet("t6.after2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 16: memory data width.
REQ-003 SHALL have parameter LINE_WORDS, default 4: words per cache line; power of two, at least 2; IDX_W = log2(LINE_WORDS).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port n_rst, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port i_req, input, 1 bit: I-cache line refill request, level, held until i_done.
REQ-007 SHALL have port i_addr, input, ADDR_W bits: I-cache miss address; low IDX_W bits ignored.
REQ-008 SHALL have port d_req, input, 1 bit: D-cache line request, level, held until d_done.
REQ-009 SHALL have port d_we, input, 1 bit: 1 = write-back line, 0 = refill line.
REQ-010 SHALL have port d_addr, input, ADDR_W bits: D-cache line address; low IDX_W bits ignored.
REQ-011 SHALL have port d_wdata, input, DATA_W bits: write-back word selected by word_idx.
REQ-012 SHALL have port mem_req, output, 1 bit: memory access request.
REQ-013 SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-014 SHALL have port mem_addr, output, ADDR_W bits: memory word address.
REQ-015 SHALL have port mem_wdata, output, DATA_W bits: memory write data.
REQ-016 SHALL have port mem_ack, input, 1 bit: current word completed this cycle.
REQ-017 SHALL have port mem_rdata, input, DATA_W bits: read word, valid with mem_ack.
REQ-018 SHALL have port rdata, output, DATA_W bits: mem_rdata passed through to both caches.
REQ-019 SHALL have port i_valid, output, 1 bit: rdata is an I-cache fill word.
REQ-020 SHALL have port d_valid, output, 1 bit: rdata is a D-cache fill word.
REQ-021 SHALL have port word_idx, output, IDX_W bits: word index of the current beat.
REQ-022 SHALL have port i_done, output, 1 bit: one-cycle I line-complete pulse.
REQ-023 SHALL have port d_done, output, 1 bit: one-cycle D line-complete pulse.

Function
REQ-024 SHALL implement FSM states IDLE, XFER and DONE, plus a grant register (I or D) and a last_grant register.
REQ-025 IDLE: with exactly one of i_req/d_req high, SHALL grant that requester and enter XFER next cycle.
REQ-026 IDLE, both requests high: SHALL grant the requester opposite last_grant (round-robin).
REQ-027 On grant, SHALL latch the line base (address with low IDX_W bits cleared), latch we (d_we for D, 0 for I), clear word_idx, and set last_grant to the granted requester.
REQ-028 XFER: SHALL drive mem_req=1, mem_we=latched we, mem_addr = base | word_idx, mem_wdata = d_wdata.
REQ-029 XFER, on mem_ack: word_idx SHALL increment; i_valid (I grant) or d_valid (D refill) SHALL equal mem_ack in that cycle, combinationally.
REQ-030 d_valid SHALL stay 0 during a write-back.
REQ-031 On mem_ack with word_idx = LINE_WORDS-1: SHALL wrap word_idx to 0 and enter DONE.
REQ-032 DONE: SHALL pulse the granted requester's i_done/d_done for exactly one cycle, then enter IDLE; requests SHALL NOT be sampled in DONE.
REQ-033 Minimum gap between transfers SHALL be one DONE plus one IDLE cycle.
REQ-034 Once XFER starts, the transfer SHALL complete all LINE_WORDS beats even if the request drops; d_we/i_addr/d_addr changes SHALL be ignored.
REQ-035 mem_ack outside XFER SHALL be ignored.
REQ-036 mem_req, mem_we, i_valid, d_valid, i_done and d_done SHALL all be 0 outside the states where they are defined above.
REQ-037 rdata SHALL equal mem_rdata at all times.

Reset
REQ-038 With n_rst low, regardless of clk and including mid-transfer: state=IDLE, word_idx=0, base=0, we=0, last_grant=I (so D wins the first contention).
REQ-039 With n_rst low: all outputs 0 except rdata.
REQ-040 An aborted transfer SHALL NOT produce a done pulse.

Verification
REQ-041 Bench SHALL cover: d_req=1, d_we=0, d_addr=0x1237, mem_ack every cycle -> mem_addr 0x1234..0x1237 on consecutive cycles; d_valid for 4 cycles; d_done one cycle later.
REQ-042 Bench SHALL cover: i_req and d_req both rise in the same cycle after reset -> D served first, then I; on the next simultaneous pair, I is served first.
REQ-043 Bench SHALL cover: I refill with mem_ack held low for 3 cycles per beat -> mem_addr and word_idx hold steady while waiting; i_valid exactly 4 pulses; i_done exactly once.
REQ-044 Bench SHALL cover: write-back d_we=1 -> mem_we=1 for all beats; mem_wdata follows d_wdata; d_valid stays 0.
REQ-045 Bench SHALL cover: n_rst low after beat 2 -> outputs 0 asynchronously; no done pulse; a fresh request restarts at word_idx 0.
REQ-046 Bench SHALL cover: d_req dropped mid-line -> all 4 beats still issued; d_done pulses once.
